// File: rtl/mem_port_arbiter_if.sv
// Request/grant and memory-side signals shared by the CPU, the debug port and the memory.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the unified MIPS memory: zero-latency grant, bounded-burst
// fairness between CPU and debug port, and read-data steering one cycle after the grant.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAXBURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus
);
  localparam int            CW      = $clog2(MAXBURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAXBURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  owner_e        r_owner;
  owner_e        r_rd_owner;
  logic [CW-1:0] r_cnt;

  owner_e        w_sel;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_at_max;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;

  assign w_at_max = (r_cnt == CNT_MAX);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_sel = OWN_NONE;
    if (rst) begin
      w_sel = OWN_NONE;
    end else if (r_owner == OWN_CPU && bus.cpu_req && !(bus.dbg_req && w_at_max)) begin
      w_sel = OWN_CPU;
    end else if (r_owner == OWN_DBG && bus.dbg_req && !(bus.cpu_req && w_at_max)) begin
      w_sel = OWN_DBG;
    end else if (bus.cpu_req && bus.dbg_req) begin
      // Contention: hand over to whoever is not the current owner; CPU wins from idle.
      w_sel = (r_owner == OWN_CPU) ? OWN_DBG : OWN_CPU;
    end else if (bus.cpu_req) begin
      w_sel = OWN_CPU;
    end else if (bus.dbg_req) begin
      w_sel = OWN_DBG;
    end
  end

  always_comb begin
    w_cnt_nxt = '0;
    if (w_sel == OWN_NONE) begin
      w_cnt_nxt = '0;
    end else if (w_sel != r_owner) begin
      w_cnt_nxt = CW'(1);
    end else if (w_at_max) begin
      w_cnt_nxt = r_cnt;
    end else begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    case (w_sel)
      OWN_CPU: begin
        w_mem_we    = bus.cpu_we;
        w_mem_addr  = bus.cpu_addr;
        w_mem_wdata = bus.cpu_wdata;
      end
      OWN_DBG: begin
        w_mem_we    = bus.dbg_we;
        w_mem_addr  = bus.dbg_addr;
        w_mem_wdata = bus.dbg_wdata;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner    <= OWN_NONE;
      r_cnt      <= '0;
      r_rd_owner <= OWN_NONE;
    end else begin
      r_owner    <= w_sel;
      r_cnt      <= w_cnt_nxt;
      r_rd_owner <= (w_sel != OWN_NONE && !w_mem_we) ? w_sel : OWN_NONE;
    end
  end

  assign bus.cpu_gnt   = (w_sel == OWN_CPU);
  assign bus.dbg_gnt   = (w_sel == OWN_DBG);
  assign bus.cpu_stall = bus.cpu_req && (w_sel != OWN_CPU);

  assign bus.mem_en    = (w_sel != OWN_NONE);
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;

  // A read landing while reset is held is discarded rather than returned.
  assign bus.cpu_rvalid = !rst && (r_rd_owner == OWN_CPU);
  assign bus.dbg_rvalid = !rst && (r_rd_owner == OWN_DBG);
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
  assign bus.dbg_rdata  = bus.dbg_rvalid ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a queue-based driver, a memory model, and a
// negedge monitor that checks grants/memory outputs and pops expected read returns.
module tb_mem_port_arbiter;
  localparam int MAXBURST = 4;
  localparam int P_NONE = 0, P_CPU = 1, P_DBG = 2;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          who;
    logic [31:0] data;
    int          due;
  } rd_t;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .MAXBURST(MAXBURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[15:0]};
  endfunction

  // Memory device: one-cycle read latency.
  logic [31:0] dev_mem [logic [31:0]];
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we) dev_mem[bus.mem_addr] = bus.mem_wdata;
      else bus.mem_rdata <= dev_mem.exists(bus.mem_addr) ? dev_mem[bus.mem_addr]
                                                         : mem_init(bus.mem_addr);
    end
  end

  // Request queues; the head of each queue is held on the bus until the model grants it.
  req_t cpu_q[$];
  req_t dbg_q[$];
  bit   g_cpu, g_dbg;

  initial begin
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (g_cpu && cpu_q.size() > 0) void'(cpu_q.pop_front());
      if (g_dbg && dbg_q.size() > 0) void'(dbg_q.pop_front());
      if (cpu_q.size() > 0) begin
        bus.cpu_req = 1; bus.cpu_we = cpu_q[0].we;
        bus.cpu_addr = cpu_q[0].addr; bus.cpu_wdata = cpu_q[0].wdata;
      end else begin
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      end
      if (dbg_q.size() > 0) begin
        bus.dbg_req = 1; bus.dbg_we = dbg_q[0].we;
        bus.dbg_addr = dbg_q[0].addr; bus.dbg_wdata = dbg_q[0].wdata;
      end else begin
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
      end
    end
  end

  // Reference model: who currently holds the port and how long its unbroken run is.
  int          m_owner = P_NONE;
  int          m_run   = 0;
  logic [31:0] shadow [logic [31:0]];
  rd_t         rdq[$];
  int          cyc = 0;
  bit          log_en = 0;
  int          trace[$];
  int          n_cpu_rv = 0;
  logic [31:0] last_cpu_rdata = '0;

  function automatic int pick(input bit c, input bit d);
    if (c && d) begin
      if (m_owner != P_NONE && m_run < MAXBURST) return m_owner;
      return (m_owner == P_CPU) ? P_DBG : P_CPU;
    end
    if (c) return P_CPU;
    if (d) return P_DBG;
    return P_NONE;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      begin
        bit          rv_c, rv_d;
        logic [1:0]  exp_rv;
        int          sel;
        bit          e_we;
        logic [31:0] e_addr, e_wdata;
        rv_c = (bus.cpu_rvalid === 1'b1);
        rv_d = (bus.dbg_rvalid === 1'b1);
        if (rv_c) n_cpu_rv++;
        exp_rv = 2'b00;
        if (!rst && rdq.size() > 0 && rdq[0].due == cyc)
          exp_rv = (rdq[0].who == P_CPU) ? 2'b10 : 2'b01;
        check("rvalid", {62'd0, rv_c, rv_d}, {62'd0, exp_rv});
        if (exp_rv != 2'b00) begin
          rd_t e;
          e = rdq.pop_front();
          if (e.who == P_CPU) begin
            check("cpu_rdata", bus.cpu_rdata, e.data);
            check("dbg_rdata_idle", bus.dbg_rdata, 0);
            last_cpu_rdata = bus.cpu_rdata;
          end else begin
            check("dbg_rdata", bus.dbg_rdata, e.data);
            check("cpu_rdata_idle", bus.cpu_rdata, 0);
          end
        end else begin
          check("rdata_idle", {bus.cpu_rdata, bus.dbg_rdata}, 0);
        end

        if (rst) begin
          rdq.delete();
          m_owner = P_NONE;
          m_run   = 0;
          sel     = P_NONE;
        end else begin
          sel = pick(bus.cpu_req, bus.dbg_req);
        end
        e_we = 0; e_addr = '0; e_wdata = '0;
        if (sel == P_CPU) begin
          e_we = bus.cpu_we; e_addr = bus.cpu_addr; e_wdata = bus.cpu_wdata;
        end else if (sel == P_DBG) begin
          e_we = bus.dbg_we; e_addr = bus.dbg_addr; e_wdata = bus.dbg_wdata;
        end
        check("cpu_gnt", bus.cpu_gnt, sel == P_CPU);
        check("dbg_gnt", bus.dbg_gnt, sel == P_DBG);
        check("cpu_stall", bus.cpu_stall, bus.cpu_req && sel != P_CPU);
        check("mem_ctl", {bus.mem_en, bus.mem_we}, {sel != P_NONE, e_we});
        check("mem_addr", bus.mem_addr, e_addr);
        check("mem_wdata", bus.mem_wdata, e_wdata);

        if (log_en && sel != P_NONE)
          trace.push_back(bus.cpu_gnt === 1'b1 ? P_CPU : (bus.dbg_gnt === 1'b1 ? P_DBG : 3));

        if (sel != P_NONE) begin
          if (e_we) begin
            shadow[e_addr] = e_wdata;
          end else begin
            rd_t r;
            r.who  = sel;
            r.data = shadow.exists(e_addr) ? shadow[e_addr] : mem_init(e_addr);
            r.due  = cyc + 1;
            rdq.push_back(r);
          end
        end
        if (!rst) begin
          if (sel == P_NONE)        m_run = 0;
          else if (sel != m_owner)  m_run = 1;
          else if (m_run < MAXBURST) m_run = m_run + 1;
          m_owner = sel;
        end
        g_cpu = (sel == P_CPU);
        g_dbg = (sel == P_DBG);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic bit busy();
    return (cpu_q.size() > 0) || (dbg_q.size() > 0) || (rdq.size() > 0);
  endfunction

  task automatic wait_idle(input string tag, input int max_cycles);
    int i = 0;
    while (busy() && i < max_cycles) begin
      step();
      i++;
    end
    check({"drain_", tag}, busy(), 0);
  endtask

  function automatic req_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic logic [31:0] pack_trace(input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++)
      v = (v << 2) | ((i < trace.size()) ? 32'(trace[i]) : 32'd3);
    return v;
  endfunction

  function automatic logic [31:0] pack_str(input string s);
    logic [31:0] v = '0;
    for (int i = 0; i < s.len(); i++)
      v = (v << 2) | ((s[i] == "C") ? 32'd1 : 32'd2);
    return v;
  endfunction

  initial begin
    int rv_before;
    rst = 1;
    repeat (3) step();
    rst = 0;

    // CPU-only back-to-back reads.
    cpu_q.push_back(mk(0, 32'h10, 0));
    cpu_q.push_back(mk(0, 32'h14, 0));
    cpu_q.push_back(mk(0, 32'h18, 0));
    wait_idle("cpu_reads", 50);

    // Both held high from idle: CPU first, then bursts of MAXBURST alternate.
    trace.delete();
    log_en = 1;
    for (int i = 0; i < 12; i++) begin
      cpu_q.push_back(mk(0, 32'h80 + 32'(4 * i), 0));
      dbg_q.push_back(mk(1, 32'hC0 + 32'(4 * i), $urandom));
    end
    wait_idle("burst", 100);
    log_en = 0;
    check("burst_pattern", pack_trace(12), pack_str("CCCCDDDDCCCC"));

    // Debug write then CPU read of the same word.
    dbg_q.push_back(mk(1, 32'h40, 32'hDEADBEEF));
    wait_idle("dbg_wr", 20);
    cpu_q.push_back(mk(0, 32'h40, 0));
    wait_idle("cpu_rd40", 20);
    check("wr_rd_40", last_cpu_rdata, 32'hDEADBEEF);

    // Reset in the cycle after a CPU read grant drops the pending return.
    cpu_q.push_back(mk(0, 32'h20, 0));
    step();
    step();
    rv_before = n_cpu_rv;
    rst = 1;
    step();
    rst = 0;
    step();
    step();
    check("rst_drop_rvalid", n_cpu_rv - rv_before, 0);
    cpu_q.push_back(mk(0, 32'h24, 0));
    dbg_q.push_back(mk(0, 32'h28, 0));
    wait_idle("post_rst", 20);

    // CPU releases after two grants while DBG waits; CPU re-requests later.
    trace.delete();
    log_en = 1;
    cpu_q.push_back(mk(0, 32'h100, 0));
    cpu_q.push_back(mk(0, 32'h104, 0));
    for (int i = 0; i < 6; i++) dbg_q.push_back(mk(0, 32'h200 + 32'(4 * i), 0));
    step();
    step();
    step();
    cpu_q.push_back(mk(0, 32'h108, 0));
    cpu_q.push_back(mk(1, 32'h10C, 32'h1234_5678));
    wait_idle("release", 100);
    log_en = 0;
    check("release_pattern", pack_trace(10), pack_str("CCDDDDCCDD"));

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (rst) rst = 0;
      else if ($urandom_range(199) == 0) rst = 1;
      if (cpu_q.size() < 3 && $urandom_range(1) == 1)
        cpu_q.push_back(mk(1'($urandom_range(1)), 32'($urandom_range(15)) << 2, $urandom));
      if (dbg_q.size() < 3 && $urandom_range(2) == 0)
        dbg_q.push_back(mk(1'($urandom_range(1)), 32'($urandom_range(15)) << 2, $urandom));
      step();
    end
    rst = 0;
    wait_idle("random", 200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
